data_bus_if: RTL

- Data-side bus interface sitting directly downstream of the memory-access stage.
- Converts the stage's single-cycle RAM request (ce/we/sel/addr/data) into a Wishbone classic master transaction.
- Returns read data to the stage.
- Raises a pipeline stall request until the bus acknowledges, and holds the result while the pipeline is frozen by other stall sources.

---
 rtl/data_bus_if_if.sv | 50 +++++
 rtl/data_bus_if.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/data_bus_if_if.sv
// Bundles the memory-stage request/response signals and the Wishbone classic
// master port of data_bus_if; master = the bridge's view, slave = the environment's view.
interface data_bus_if_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int SEL_W = DATA_W / 8;

   // pipeline control
   logic [5:0]        stall_i;
   logic              flush_i;
   logic              stallreq_o;

   // memory-stage request and load return
   logic              cpu_ce_i;
   logic              cpu_we_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [SEL_W-1:0]  cpu_sel_i;
   logic [DATA_W-1:0] cpu_data_i;
   logic [DATA_W-1:0] cpu_data_o;

   // Wishbone classic: a cycle runs while cyc=stb=1 and ends on the first ack
   logic [ADDR_W-1:0] wb_adr_o;
   logic [DATA_W-1:0] wb_dat_o;
   logic [DATA_W-1:0] wb_dat_i;
   logic              wb_we_o;
   logic [SEL_W-1:0]  wb_sel_o;
   logic              wb_stb_o;
   logic              wb_cyc_o;
   logic              wb_ack_i;

   logic              bus_err_o;
   logic [1:0]        dbg_state;

   modport master (
      input  stall_i, flush_i, cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i,
      input  wb_dat_i, wb_ack_i,
      output stallreq_o, cpu_data_o,
      output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
      output bus_err_o, dbg_state
   );

   modport slave (
      output stall_i, flush_i, cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_data_i,
      output wb_dat_i, wb_ack_i,
      input  stallreq_o, cpu_data_o,
      input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
      input  bus_err_o, dbg_state
   );
endinterface

// File: rtl/data_bus_if.sv
// Memory-stage to Wishbone classic master bridge with stall request and result hold.
// Optional macro BUS_TIMEOUT_EN adds a BUSY watchdog that aborts and pulses bus_err_o.
module data_bus_if #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic           clk,
   input  logic           rst,
   data_bus_if_if.master  bus
);
   localparam int SEL_W = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;

   logic              start_req;
   logic              ack_done;
   logic              abort_flush;
   logic              abort_tmo;
   logic              tmo_last;
   logic              stallreq;
   logic [DATA_W-1:0] cpu_data;

   logic [DATA_W-1:0] rd_buf;
   logic [ADDR_W-1:0] wb_adr;
   logic [DATA_W-1:0] wb_dat;
   logic              wb_we;
   logic [SEL_W-1:0]  wb_sel;
   logic              wb_stb;
   logic              wb_cyc;

`ifdef BUS_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

   logic [TMO_W-1:0] tmo_cnt;
   logic             bus_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (start_req) begin
         tmo_cnt <= '0;
      end else if (state == ST_BUSY && !bus.wb_ack_i) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   assign tmo_last = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) bus_err <= 1'b0;
      else     bus_err <= abort_tmo;
   end

   assign bus.bus_err_o = bus_err;
`else
   logic unused_tmo_cfg;

   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
   assign tmo_last       = 1'b0;
   assign bus.bus_err_o  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next  = state;
      start_req   = 1'b0;
      ack_done    = 1'b0;
      abort_flush = 1'b0;
      abort_tmo   = 1'b0;
      stallreq    = 1'b0;
      cpu_data    = rd_buf;
      case (state)
         ST_IDLE: begin
            if (bus.cpu_ce_i && !bus.flush_i) begin
               start_req  = 1'b1;
               stallreq   = 1'b1;
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // flush wins over a same-cycle ack; the acked data is dropped
            if (bus.flush_i) begin
               abort_flush = 1'b1;
               state_next  = ST_IDLE;
            end else if (bus.wb_ack_i) begin
               ack_done   = 1'b1;
               cpu_data   = bus.wb_dat_i;
               state_next = (|bus.stall_i) ? ST_WAIT : ST_IDLE;
            end else if (tmo_last) begin
               abort_tmo  = 1'b1;
               cpu_data   = '0;
               state_next = (|bus.stall_i) ? ST_WAIT : ST_IDLE;
            end else begin
               stallreq = 1'b1;
            end
         end
         ST_WAIT: begin
            // the memory stage still presents the finished request; hold off until it moves on
            if (bus.flush_i) begin
               abort_flush = 1'b1;
               state_next  = ST_IDLE;
            end else if (bus.stall_i == 6'b0) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (rst) begin
         stallreq = 1'b0;
         cpu_data = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_adr <= '0;
         wb_dat <= '0;
         wb_we  <= 1'b0;
         wb_sel <= '0;
         wb_stb <= 1'b0;
         wb_cyc <= 1'b0;
         rd_buf <= '0;
      end else begin
         if (start_req) begin
            wb_adr <= bus.cpu_addr_i;
            wb_dat <= bus.cpu_data_i;
            wb_we  <= bus.cpu_we_i;
            wb_sel <= bus.cpu_sel_i;
            wb_stb <= 1'b1;
            wb_cyc <= 1'b1;
         end else if (ack_done || abort_flush || abort_tmo) begin
            wb_we  <= 1'b0;
            wb_sel <= '0;
            wb_stb <= 1'b0;
            wb_cyc <= 1'b0;
         end
         if (ack_done && !wb_we) begin
            rd_buf <= bus.wb_dat_i;
         end else if (abort_flush || abort_tmo) begin
            rd_buf <= '0;
         end
      end
   end

   assign bus.wb_adr_o   = wb_adr;
   assign bus.wb_dat_o   = wb_dat;
   assign bus.wb_we_o    = wb_we;
   assign bus.wb_sel_o   = wb_sel;
   assign bus.wb_stb_o   = wb_stb;
   assign bus.wb_cyc_o   = wb_cyc;
   assign bus.stallreq_o = stallreq;
   assign bus.cpu_data_o = cpu_data;
   assign bus.dbg_state  = state;
endmodule
